// File: rtl/sub_pe.sv
// Per-lane dot-product unit: unsigned DW x DW multiply-accumulate over a window of N pairs.
// Capture stage registers img*weight; accumulate stage adds it one edge later.
module sub_pe #(
  parameter int unsigned DW    = 8,
  parameter int unsigned CW    = 3,
  parameter int unsigned ACC_W = 2 * DW + CW
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             start_i,
  input  logic [DW-1:0]    img_i,
  input  logic [DW-1:0]    weight_i,
  input  logic [CW-1:0]    channel_i,
  output logic [ACC_W-1:0] result_o,
  output logic             out_valid_o,
  output logic             busy_o
);

  typedef enum logic [1:0] {StIdle, StRun, StFlush} state_e;

  localparam logic [CW:0] CntOne = CW'(1) + (CW+1)'(0);

  state_e              state_q, state_d;
  logic   [CW:0]       n_q, n_d;
  logic   [CW:0]       cnt_q, cnt_d;
  logic   [2*DW-1:0]   prod_q, prod_d;
  logic   [ACC_W-1:0]  acc_q, acc_d;
  logic   [ACC_W-1:0]  result_q, result_d;
  logic                valid_q, valid_d;

  logic   [CW:0]       chan_n;
  logic   [2*DW-1:0]   prod_new;
  logic   [ACC_W-1:0]  acc_sum;

  // channel == 0 encodes the full 2^CW window
  assign chan_n   = (channel_i == '0) ? {1'b1, {CW{1'b0}}} : {1'b0, channel_i};
  assign prod_new = img_i * weight_i;
  assign acc_sum  = acc_q + ACC_W'(prod_q);

  always_comb begin
    state_d  = state_q;
    n_d      = n_q;
    cnt_d    = cnt_q;
    prod_d   = prod_q;
    acc_d    = acc_q;
    result_d = result_q;
    valid_d  = 1'b0;

    unique case (state_q)
      StIdle: ;
      StRun: begin
        acc_d  = acc_sum;
        prod_d = prod_new;
        cnt_d  = cnt_q + CntOne;
        if (cnt_d == n_q) state_d = StFlush;
      end
      StFlush: begin
        result_d = acc_sum;
        valid_d  = 1'b1;
        state_d  = StIdle;
      end
      default: state_d = StIdle;
    endcase

    // A start aborts a running window, or chains after a completing one; the
    // flush's result update above still lands because acc and result are separate.
    if (start_i) begin
      n_d     = chan_n;
      cnt_d   = CntOne;
      prod_d  = prod_new;
      acc_d   = '0;
      state_d = (chan_n == CntOne) ? StFlush : StRun;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q  <= StIdle;
      n_q      <= '0;
      cnt_q    <= '0;
      prod_q   <= '0;
      acc_q    <= '0;
      result_q <= '0;
      valid_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      n_q      <= n_d;
      cnt_q    <= cnt_d;
      prod_q   <= prod_d;
      acc_q    <= acc_d;
      result_q <= result_d;
      valid_q  <= valid_d;
    end
  end

  assign result_o    = result_q;
  assign out_valid_o = valid_q;
  assign busy_o      = (state_q != StIdle);

endmodule

// File: tb/tb_sub_pe.sv
// Directed bench for sub_pe: hand-computed window sums, restart, reset and chaining cases.
module tb_sub_pe;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        start_i;
  logic [7:0]  img_i;
  logic [7:0]  weight_i;
  logic [2:0]  channel_i;
  logic [18:0] result_o;
  logic        out_valid_o;
  logic        busy_o;

  int checks = 0;
  int fails  = 0;
  int vcnt   = 0;
  int vbase;

  always #5 clk_i = ~clk_i;

  sub_pe dut (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .start_i     (start_i),
    .img_i       (img_i),
    .weight_i    (weight_i),
    .channel_i   (channel_i),
    .result_o    (result_o),
    .out_valid_o (out_valid_o),
    .busy_o      (busy_o)
  );

  task automatic tick();
    @(posedge clk_i);
    #1;
    if (out_valid_o) vcnt++;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic s, input logic [7:0] a, input logic [7:0] b);
    start_i  = s;
    img_i    = a;
    weight_i = b;
  endtask

  initial begin
    rst_ni = 1'b0; channel_i = 3'd0;
    drive(1'b0, 8'd0, 8'd0);
    tick(); tick();
    check("rst_result", 32'(result_o), 32'd0);
    check("rst_valid", 32'(out_valid_o), 32'd0);
    check("rst_busy", 32'(busy_o), 32'd0);
    rst_ni = 1'b1;
    tick();

    // 1: N=3, 3*1+4*2+5*3 = 26
    channel_i = 3'd3; drive(1'b1, 8'd3, 8'd1); tick();
    check("t1_busy_e0", 32'(busy_o), 32'd1);
    check("t1_valid_e0", 32'(out_valid_o), 32'd0);
    channel_i = 3'd0; drive(1'b0, 8'd4, 8'd2); tick();
    drive(1'b0, 8'd5, 8'd3); tick();
    check("t1_busy_e2", 32'(busy_o), 32'd1);
    check("t1_valid_e2", 32'(out_valid_o), 32'd0);
    drive(1'b0, 8'd0, 8'd0); tick();
    check("t1_valid", 32'(out_valid_o), 32'd1);
    check("t1_result", 32'(result_o), 32'd26);
    check("t1_busy_done", 32'(busy_o), 32'd0);
    tick();
    check("t1_valid_pulse", 32'(out_valid_o), 32'd0);
    check("t1_result_hold", 32'(result_o), 32'd26);

    // 2: N=1, single max product
    channel_i = 3'd1; drive(1'b1, 8'd255, 8'd255); tick();
    check("t2_busy", 32'(busy_o), 32'd1);
    check("t2_valid_early", 32'(out_valid_o), 32'd0);
    drive(1'b0, 8'd0, 8'd0); tick();
    check("t2_valid", 32'(out_valid_o), 32'd1);
    check("t2_result", 32'(result_o), 32'd65025);
    check("t2_busy_done", 32'(busy_o), 32'd0);

    // 3: channel=0 means N=8, full-range sum
    channel_i = 3'd0; drive(1'b1, 8'd255, 8'd255); tick();
    drive(1'b0, 8'd255, 8'd255);
    vbase = vcnt;
    for (int i = 1; i < 8; i++) tick();
    check("t3_no_early_valid", 32'(vcnt - vbase), 32'd0);
    check("t3_busy_last", 32'(busy_o), 32'd1);
    drive(1'b0, 8'd0, 8'd0); tick();
    check("t3_valid", 32'(out_valid_o), 32'd1);
    check("t3_result", 32'(result_o), 32'd520200);

    // 4: restart at E0+1 aborts first window; 1+4+9 = 14
    vbase = vcnt;
    channel_i = 3'd3; drive(1'b1, 8'd9, 8'd9); tick();
    drive(1'b1, 8'd1, 8'd1); tick();
    channel_i = 3'd5; drive(1'b0, 8'd2, 8'd2); tick();
    drive(1'b0, 8'd3, 8'd3); tick();
    check("t4_busy_before", 32'(busy_o), 32'd1);
    drive(1'b0, 8'd0, 8'd0); tick();
    check("t4_valid", 32'(out_valid_o), 32'd1);
    check("t4_result", 32'(result_o), 32'd14);
    tick(); tick(); tick();
    check("t4_single_valid", 32'(vcnt - vbase), 32'd1);

    // 5: reset mid-window drops the window and clears result
    vbase = vcnt;
    channel_i = 3'd3; drive(1'b1, 8'd7, 8'd7); tick();
    rst_ni = 1'b0; drive(1'b0, 8'd7, 8'd7); tick();
    check("t5_busy", 32'(busy_o), 32'd0);
    check("t5_valid", 32'(out_valid_o), 32'd0);
    check("t5_result", 32'(result_o), 32'd0);
    rst_ni = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    check("t5_no_valid", 32'(vcnt - vbase), 32'd0);
    check("t5_busy_idle", 32'(busy_o), 32'd0);

    // 6: start at completion edge; 2*3+4*5=26 then 1*2+3*4+5*6=44
    channel_i = 3'd2; drive(1'b1, 8'd2, 8'd3); tick();
    drive(1'b0, 8'd4, 8'd5); tick();
    channel_i = 3'd3; drive(1'b1, 8'd1, 8'd2); tick();
    check("t6_first_valid", 32'(out_valid_o), 32'd1);
    check("t6_first_result", 32'(result_o), 32'd26);
    check("t6_busy_chain", 32'(busy_o), 32'd1);
    drive(1'b0, 8'd3, 8'd4); tick();
    check("t6_valid_gap", 32'(out_valid_o), 32'd0);
    drive(1'b0, 8'd5, 8'd6); tick();
    drive(1'b0, 8'd0, 8'd0); tick();
    check("t6_second_valid", 32'(out_valid_o), 32'd1);
    check("t6_second_result", 32'(result_o), 32'd44);
    check("t6_busy_done", 32'(busy_o), 32'd0);

    // Idle: inputs ignored, result held
    vbase = vcnt;
    drive(1'b0, 8'd200, 8'd100); channel_i = 3'd4;
    for (int i = 0; i < 3; i++) tick();
    check("idle_no_valid", 32'(vcnt - vbase), 32'd0);
    check("idle_result_hold", 32'(result_o), 32'd44);
    check("idle_busy", 32'(busy_o), 32'd0);

    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule
